mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, byte address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; byte-enable width = DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while an inst request waits.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports i_req in 1, i_we in DATA_W/8, i_addr in ADDR_W, i_wdata in DATA_W: inst-side request; fields held stable until i_ack.
REQ-007 SHALL have ports i_ack out 1 (access done) and i_rdata out DATA_W (read data).
REQ-008 SHALL have ports d_req, d_we, d_addr, d_wdata (in) and d_ack, d_rdata (out): data-side request and response, same widths and rules as inst side.
REQ-009 SHALL have ports m_en out 1, m_we out DATA_W/8, m_addr out ADDR_W, m_wdata out DATA_W, m_rdata in DATA_W: shared single-port sram with 1-cycle read latency.
REQ-010 SHALL have port conflict_cnt  out  32  count of cycles where both requests competed for an issue slot.

Function
REQ-011 SHALL implement FSM states IDLE, RESP_I, RESP_D.
REQ-012 SHALL, in IDLE with at least one req, issue in the same cycle: m_en=1, m_we/m_addr/m_wdata copied combinationally from the winner; next state RESP_I or RESP_D.
REQ-013 SHALL, in IDLE with no req, stay in IDLE with m_en=0.
REQ-014 SHALL drive m_we, m_addr and m_wdata to 0 whenever m_en=0.
REQ-015 SHALL, in RESP_x, assert x_ack=1 for exactly one cycle with x_rdata=m_rdata, then return to IDLE.
REQ-016 SHALL hold m_en=0 in RESP_x; no new issue occurs in a response cycle, so throughput is one access per 2 cycles.
REQ-017 SHALL drive x_rdata=0 whenever x_ack=0.
REQ-018 SHALL ack writes like reads; rdata on a write ack is don't-care but SHALL still equal m_rdata.
REQ-019 SHALL arbitrate by these rules when only one req is high: that requester wins.
REQ-020 SHALL arbitrate by these rules when both reqs are high: data wins unless starve_cnt==STARVE_MAX, in which case inst wins.
REQ-021 SHALL keep an internal starve_cnt that increments on a data grant while i_req=1, saturating at STARVE_MAX.
REQ-022 SHALL clear starve_cnt to 0 on any inst grant, and on any IDLE cycle with i_req=0.
REQ-023 SHALL ignore a requester's req in the cycle its ack is asserted; the requester drops req or presents a new request from the next cycle.
REQ-024 SHALL increment conflict_cnt by 1 in each IDLE cycle with i_req=1 and d_req=1, saturating at 32'hFFFF_FFFF.
REQ-025 SHALL not alter the in-flight access when req changes during RESP_x; the ack still goes to x.

Reset
REQ-026 SHALL, while reset=1, force state=IDLE, starve_cnt=0 and conflict_cnt=0.
REQ-027 SHALL, while reset=1, drive m_en=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0.
REQ-028 SHALL treat reset asserted in RESP_x as an abort: no ack is produced, and the requester re-issues after reset.
REQ-029 SHALL sample reqs only in IDLE once reset deasserts, issuing no earlier than the first cycle after reset falls.

Verification
REQ-030 SHALL pass this case: i_req only, i_addr=0x8000_0000, m_rdata=0x1234 next cycle -> m_en=1 in cycle 0; i_ack=1 and i_rdata=0x1234 in cycle 1; d_ack=0 throughout.
REQ-031 SHALL pass this case: i_req and d_req both held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I...; each ack spaced 2 cycles; conflict_cnt +1 per IDLE cycle.
REQ-032 SHALL pass this case: d_req write with d_we=0xFF, d_addr=0x100, d_wdata=0xDEAD -> m_en=1, m_we=0xFF, m_addr=0x100, m_wdata=0xDEAD for 1 cycle; d_ack next cycle.
REQ-033 SHALL pass this case: reset asserted in RESP_D -> no d_ack; all outputs 0 next cycle; conflict_cnt=0.
REQ-034 SHALL pass this case: i_req drops during a data-only run -> starve_cnt clears; a later conflict is granted to data first.
REQ-035 SHALL pass this case: conflict_cnt preloaded near saturation by forced long conflict -> holds at 0xFFFF_FFFF, no wrap.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction port and a data port onto one single-port SRAM with 1-cycle read latency.
// Data normally wins; a waiting instruction request is granted after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_req,
   input  logic [DATA_W/8-1:0] i_we,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic                i_ack,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic [DATA_W/8-1:0] d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_ack,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_en,
   output logic [DATA_W/8-1:0] m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic [31:0]         conflict_cnt
);

   localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESP_I = 2'd1,
      RESP_D = 2'd2
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [SC_W-1:0] starve_cnt;
   logic [31:0]     conflict_cnt_q;
   logic            grant_i;
   logic            grant_d;

   assign conflict_cnt = conflict_cnt_q;

   // Next-state, arbitration and SRAM/response drive; everything is gated to 0 under reset.
   always_comb begin
      next_state = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      m_en       = 1'b0;
      m_we       = '0;
      m_addr     = '0;
      m_wdata    = '0;
      i_ack      = 1'b0;
      i_rdata    = '0;
      d_ack      = 1'b0;
      d_rdata    = '0;
      if (reset) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (i_req && (!d_req || (starve_cnt == STARVE_LIM))) begin
                  grant_i    = 1'b1;
                  m_en       = 1'b1;
                  m_we       = i_we;
                  m_addr     = i_addr;
                  m_wdata    = i_wdata;
                  next_state = RESP_I;
               end else if (d_req) begin
                  grant_d    = 1'b1;
                  m_en       = 1'b1;
                  m_we       = d_we;
                  m_addr     = d_addr;
                  m_wdata    = d_wdata;
                  next_state = RESP_D;
               end else begin
                  next_state = IDLE;
               end
            end
            RESP_I: begin
               i_ack      = 1'b1;
               i_rdata    = m_rdata;
               next_state = IDLE;
            end
            RESP_D: begin
               d_ack      = 1'b1;
               d_rdata    = m_rdata;
               next_state = IDLE;
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // State, starvation counter and saturating conflict counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         starve_cnt     <= '0;
         conflict_cnt_q <= 32'd0;
      end else begin
         state <= next_state;
         // A grant to inst, or inst not waiting while idle, ends the starvation window.
         if (grant_i || ((state == IDLE) && !i_req)) begin
            starve_cnt <= '0;
         end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + {{(SC_W-1){1'b0}}, 1'b1};
         end else begin
            starve_cnt <= starve_cnt;
         end
         if ((state == IDLE) && i_req && d_req && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
         end else begin
            conflict_cnt_q <= conflict_cnt_q;
         end
      end
   end

endmodule
